// File: rtl/fetch_stage_btb.sv
// fetch_stage_btb: IF stage with PC register, direct-mapped BTB predictor and IF/ID register.
// Ports: clk/reset (sync, active-high); pc_write stall control; redirect_valid/redirect_pc from EXE;
// branch_resolved/actual_taken/branch_pc/branch_target train the BTB; imem_addr/imem_rdata combinational
// instruction fetch; pc_d/instr_d/valid_d/pred_taken_d/pred_target_d form IF/ID; stat_* are saturating counters.
module fetch_stage_btb #(
  parameter int XLEN = 64,
  parameter int BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter bit PREDICT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_write,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            branch_resolved,
  input  logic            actual_taken,
  input  logic [XLEN-1:0] branch_pc,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] pc_d,
  output logic [31:0]     instr_d,
  output logic            valid_d,
  output logic            pred_taken_d,
  output logic [XLEN-1:0] pred_target_d,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);
  localparam int IDX = $clog2(BTB_ENTRIES);
  localparam int TW = XLEN - IDX - 2;
  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TW-1:0] btb_tag [BTB_ENTRIES];
  logic [XLEN-1:0] btb_target [BTB_ENTRIES];
  logic [1:0] btb_ctr [BTB_ENTRIES];
  logic [XLEN-1:0] pc_f, pred_next;
  logic [IDX-1:0] f_idx, t_idx;
  logic [1:0] t_ctr;
  logic f_hit, t_hit, pred_taken;
  logic unused_lsbs;
  assign unused_lsbs = ^{pc_f[1:0], branch_pc[1:0]};
  assign imem_addr = pc_f;
  assign f_idx = pc_f[IDX+1:2];
  assign t_idx = branch_pc[IDX+1:2];
  assign t_ctr = btb_ctr[t_idx];
  assign f_hit = btb_valid[f_idx] && btb_tag[f_idx] == pc_f[XLEN-1:IDX+2];
  assign t_hit = btb_valid[t_idx] && btb_tag[t_idx] == branch_pc[XLEN-1:IDX+2];
  assign pred_taken = PREDICT_EN && f_hit && btb_ctr[f_idx][1];
  assign pred_next = pred_taken ? btb_target[f_idx] : pc_f + XLEN'(4);
  always_ff @(posedge clk)
    if (reset) pc_f <= RESET_PC;
    else if (redirect_valid) pc_f <= redirect_pc;
    else if (pc_write) pc_f <= pred_next;
  always_ff @(posedge clk)
    if (reset || redirect_valid) begin
      pc_d <= '0;
      instr_d <= 32'h00000013;
      valid_d <= 1'b0;
      pred_taken_d <= 1'b0;
      pred_target_d <= '0;
    end else if (pc_write) begin
      pc_d <= pc_f;
      instr_d <= imem_rdata;
      valid_d <= 1'b1;
      pred_taken_d <= pred_taken;
      pred_target_d <= pred_next;
    end
  always_ff @(posedge clk)
    if (reset) begin
      btb_valid <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) btb_ctr[i] <= 2'd0;
    end else if (branch_resolved) begin
      if (t_hit) btb_ctr[t_idx] <= actual_taken ? t_ctr + {1'b0, ~&t_ctr} : t_ctr - {1'b0, |t_ctr};
      else if (actual_taken) begin
        btb_valid[t_idx] <= 1'b1;
        btb_ctr[t_idx] <= 2'd2;
      end
    end
  // A taken resolve either refreshes a hit (same tag) or allocates, so tag and target are written alike.
  always_ff @(posedge clk)
    if (!reset && branch_resolved && actual_taken) begin
      btb_tag[t_idx] <= branch_pc[XLEN-1:IDX+2];
      btb_target[t_idx] <= branch_target;
    end
  always_ff @(posedge clk)
    if (reset) begin
      stat_branches <= '0;
      stat_mispredicts <= '0;
    end else begin
      stat_branches <= stat_branches + 32'(branch_resolved && ~&stat_branches);
      stat_mispredicts <= stat_mispredicts + 32'(redirect_valid && ~&stat_mispredicts);
    end
endmodule

// File: tb/tb_fetch_stage_btb.sv
// tb_fetch_stage_btb: scoreboard bench for fetch_stage_btb with a predicting and a static instance.
module tb_fetch_stage_btb;
  typedef struct packed {
    logic [63:0] pc;
    logic        v;
    logic [31:0] ins;
    logic        p;
    logic [63:0] t;
  } ifid_t;
  localparam ifid_t BUBBLE = '{pc: 64'd0, v: 1'b0, ins: 32'h00000013, p: 1'b0, t: 64'd0};
  logic clk = 0, reset = 1, pc_write = 1, redirect_valid = 0, branch_resolved = 0, actual_taken = 0;
  logic [63:0] redirect_pc = 0, branch_pc = 0, branch_target = 0;
  logic [63:0] imem_addr, pc_d, pred_target_d, s_addr, s_pc_d, s_target_d;
  logic [31:0] imem_rdata, instr_d, stat_branches, stat_mispredicts, s_rdata, s_instr_d, s_branches, s_mispredicts;
  logic valid_d, pred_taken_d, s_valid_d, s_pred_d;
  ifid_t got, s_got, e;
  ifid_t q[$];
  int tests = 0, errors = 0;
  logic [31:0] exp_br = 0, exp_mis = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [63:0] a);
    return a[31:0] ^ 32'hDEAD0000;
  endfunction
  function automatic ifid_t exp_f(input logic [63:0] pc, input logic p, input logic [63:0] t);
    return '{pc: pc, v: 1'b1, ins: mem(pc), p: p, t: t};
  endfunction
  assign imem_rdata = mem(imem_addr);
  assign s_rdata = mem(s_addr);
  assign got = {pc_d, valid_d, instr_d, pred_taken_d, pred_target_d};
  assign s_got = {s_pc_d, s_valid_d, s_instr_d, s_pred_d, s_target_d};
  fetch_stage_btb dut (
    .clk(clk), .reset(reset), .pc_write(pc_write), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .branch_resolved(branch_resolved), .actual_taken(actual_taken), .branch_pc(branch_pc),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc_d(pc_d),
    .instr_d(instr_d), .valid_d(valid_d), .pred_taken_d(pred_taken_d), .pred_target_d(pred_target_d),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts));
  fetch_stage_btb #(.PREDICT_EN(1'b0)) u_static (
    .clk(clk), .reset(reset), .pc_write(pc_write), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .branch_resolved(branch_resolved), .actual_taken(actual_taken), .branch_pc(branch_pc),
    .branch_target(branch_target), .imem_addr(s_addr), .imem_rdata(s_rdata), .pc_d(s_pc_d),
    .instr_d(s_instr_d), .valid_d(s_valid_d), .pred_taken_d(s_pred_d), .pred_target_d(s_target_d),
    .stat_branches(s_branches), .stat_mispredicts(s_mispredicts));
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic redirect(input logic [63:0] a);
    redirect_valid = 1; redirect_pc = a; exp_mis++;
    cyc();
    redirect_valid = 0;
  endtask
  task automatic train(input logic [63:0] pc, input logic tk, input logic [63:0] tg);
    branch_resolved = 1; branch_pc = pc; actual_taken = tk; branch_target = tg; exp_br++;
    cyc();
    branch_resolved = 0;
  endtask
  task automatic test_reset();
    cyc();
    tests++; if (got !== BUBBLE) begin errors++; $display("FAIL reset_ifid got %h exp %h", got, BUBBLE); end
    tests++; if (imem_addr !== 64'd0) begin errors++; $display("FAIL reset_pc got %h exp 0", imem_addr); end
    tests++; if ({stat_branches, stat_mispredicts} !== 64'd0) begin errors++; $display("FAIL reset_stats got %h %h exp 0", stat_branches, stat_mispredicts); end
  endtask
  task automatic test_sequential();
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      tests++; if (imem_addr !== 64'(4 * i)) begin errors++; $display("FAIL seq_addr%0d got %h exp %h", i, imem_addr, 4 * i); end
      q.push_back(exp_f(64'(4 * i), 1'b0, 64'(4 * i + 4)));
      cyc();
      e = q.pop_front();
      tests++; if (got !== e) begin errors++; $display("FAIL seq_ifid%0d got %h exp %h", i, got, e); end
    end
  endtask
  task automatic test_train_taken();
    tests++; if (imem_addr !== 64'h10) begin errors++; $display("FAIL tt_addr got %h exp 10", imem_addr); end
    q.push_back(exp_f(64'h10, 1'b0, 64'h14));
    train(64'h10, 1'b1, 64'h40);
    e = q.pop_front();
    tests++; if (got !== e) begin errors++; $display("FAIL tt_no_bypass got %h exp %h", got, e); end
    redirect(64'h10);
    tests++; if (got !== BUBBLE) begin errors++; $display("FAIL tt_bubble got %h exp %h", got, BUBBLE); end
    q.push_back(exp_f(64'h10, 1'b1, 64'h40));
    cyc();
    e = q.pop_front();
    tests++; if (got !== e) begin errors++; $display("FAIL tt_pred got %h exp %h", got, e); end
    tests++; if (imem_addr !== 64'h40) begin errors++; $display("FAIL tt_target got %h exp 40", imem_addr); end
  endtask
  task automatic test_train_not_taken();
    pc_write = 0;
    train(64'h10, 1'b0, 64'h0);
    train(64'h10, 1'b0, 64'h0);
    pc_write = 1;
    e = exp_f(64'h10, 1'b1, 64'h40);
    tests++; if (got !== e) begin errors++; $display("FAIL nt_hold_ifid got %h exp %h", got, e); end
    tests++; if (imem_addr !== 64'h40) begin errors++; $display("FAIL nt_hold_pc got %h exp 40", imem_addr); end
    redirect(64'h10);
    q.push_back(exp_f(64'h10, 1'b0, 64'h14));
    cyc();
    e = q.pop_front();
    tests++; if (got !== e) begin errors++; $display("FAIL nt_pred got %h exp %h", got, e); end
    tests++; if (imem_addr !== 64'h14) begin errors++; $display("FAIL nt_next got %h exp 14", imem_addr); end
    train(64'h10, 1'b0, 64'h0);
    train(64'h10, 1'b1, 64'h40);
    redirect(64'h10);
    q.push_back(exp_f(64'h10, 1'b0, 64'h14));
    cyc();
    e = q.pop_front();
    tests++; if (got !== e) begin errors++; $display("FAIL nt_saturate got %h exp %h", got, e); end
  endtask
  task automatic test_redirect_stall();
    pc_write = 0;
    redirect(64'h200);
    pc_write = 1;
    tests++; if (imem_addr !== 64'h200) begin errors++; $display("FAIL rs_addr got %h exp 200", imem_addr); end
    tests++; if (got !== BUBBLE) begin errors++; $display("FAIL rs_bubble got %h exp %h", got, BUBBLE); end
    tests++; if (stat_mispredicts !== exp_mis) begin errors++; $display("FAIL rs_stat got %0d exp %0d", stat_mispredicts, exp_mis); end
  endtask
  task automatic test_alias();
    train(64'h10, 1'b1, 64'h40);
    train(64'h50, 1'b1, 64'h80);
    redirect(64'h10);
    q.push_back(exp_f(64'h10, 1'b0, 64'h14));
    cyc();
    redirect(64'h50);
    q.push_back(exp_f(64'h50, 1'b1, 64'h80));
    e = q.pop_front();
    tests++; if (e !== exp_f(64'h10, 1'b0, 64'h14) || q.size() != 1) begin errors++; $display("FAIL al_queue size %0d", q.size()); end
    cyc();
    e = q.pop_front();
    tests++; if (got !== e) begin errors++; $display("FAIL al_hit got %h exp %h", got, e); end
    tests++; if (imem_addr !== 64'h80) begin errors++; $display("FAIL al_target got %h exp 80", imem_addr); end
  endtask
  task automatic test_evicted();
    train(64'h50, 1'b1, 64'h80);
    train(64'h10, 1'b1, 64'h40);
    train(64'h50, 1'b1, 64'h80);
    redirect(64'h10);
    q.push_back(exp_f(64'h10, 1'b0, 64'h14));
    cyc();
    e = q.pop_front();
    tests++; if (got !== e) begin errors++; $display("FAIL ev_miss got %h exp %h", got, e); end
  endtask
  task automatic test_static();
    train(64'h10, 1'b1, 64'h40);
    redirect(64'h10);
    q.push_back(exp_f(64'h10, 1'b1, 64'h40));
    cyc();
    e = q.pop_front();
    tests++; if (got !== e) begin errors++; $display("FAIL st_dyn got %h exp %h", got, e); end
    e = exp_f(64'h10, 1'b0, 64'h14);
    tests++; if (s_got !== e) begin errors++; $display("FAIL st_static got %h exp %h", s_got, e); end
    tests++; if (s_addr !== 64'h14) begin errors++; $display("FAIL st_next got %h exp 14", s_addr); end
    tests++; if (s_branches !== exp_br) begin errors++; $display("FAIL st_branches got %0d exp %0d", s_branches, exp_br); end
    tests++; if (stat_branches !== exp_br) begin errors++; $display("FAIL dyn_branches got %0d exp %0d", stat_branches, exp_br); end
  endtask
  task automatic test_reset_mid();
    reset = 1; pc_write = 0; redirect_valid = 1; redirect_pc = 64'h300;
    branch_resolved = 1; actual_taken = 1; branch_pc = 64'h20; branch_target = 64'h60;
    cyc();
    tests++; if (got !== BUBBLE) begin errors++; $display("FAIL rm_bubble got %h exp %h", got, BUBBLE); end
    tests++; if (imem_addr !== 64'd0) begin errors++; $display("FAIL rm_pc got %h exp 0", imem_addr); end
    tests++; if ({stat_branches, stat_mispredicts} !== 64'd0) begin errors++; $display("FAIL rm_stats got %h %h exp 0", stat_branches, stat_mispredicts); end
    reset = 0; pc_write = 1; redirect_valid = 0; branch_resolved = 0; exp_br = 0; exp_mis = 0;
    q.push_back(exp_f(64'h0, 1'b0, 64'h4));
    cyc();
    e = q.pop_front();
    tests++; if (got !== e) begin errors++; $display("FAIL rm_first got %h exp %h", got, e); end
    redirect(64'h10);
    q.push_back(exp_f(64'h10, 1'b0, 64'h14));
    cyc();
    e = q.pop_front();
    tests++; if (got !== e) begin errors++; $display("FAIL rm_cleared got %h exp %h", got, e); end
    redirect(64'h20);
    q.push_back(exp_f(64'h20, 1'b0, 64'h24));
    cyc();
    e = q.pop_front();
    tests++; if (got !== e) begin errors++; $display("FAIL rm_no_train got %h exp %h", got, e); end
    tests++; if (stat_mispredicts !== exp_mis) begin errors++; $display("FAIL rm_mis got %0d exp %0d", stat_mispredicts, exp_mis); end
  endtask
  initial begin
    test_reset();
    test_sequential();
    test_train_taken();
    test_train_not_taken();
    test_redirect_stall();
    test_alias();
    test_evicted();
    test_static();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
